hack_rom_loader: RTL and testbench

Instruction-side stage sitting directly upstream of the Hack CPU.
- Owns the instruction ROM: a 1R1W synchronous RAM.
- Fills the ROM from a byte stream (UART/host bridge, valid/ready).
- Holds the CPU in reset while loading.
- Once loaded, serves `instruction[15:0]` from the CPU's `pc[14:0]`.

---
 rtl/hack_rom_loader_pkg.sv | 19 +
 rtl/hack_rom_bank.sv | 22 ++
 rtl/hack_rom_loader.sv | 176 +++++++++++++++++
 tb/tb_hack_rom_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_rom_loader_pkg.sv
// Shared loader types and constants; CHK exists only with HACK_ROM_LOADER_CHECKSUM_EN.
package hack_rom_loader_pkg;

  localparam int LEN_W_DEFAULT = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    CHK,
`endif
    RUN,
    ERR
  } loaderState_t;

endpackage

// File: rtl/hack_rom_bank.sv
// 1R1W synchronous RAM, 2**AW x DW; one-cycle registered read, write-only port for the loader.
module hack_rom_bank #(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [DW-1:0] wrData,
  input  logic [AW-1:0] rdAddr,
  output logic [DW-1:0] rdData
);

  logic [DW-1:0] mem [2**AW];

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/hack_rom_loader.sv
// Loads the Hack ROM from a big-endian LEN/words stream, holding the CPU in reset; then instruction = ROM[pc] one cycle later.
// in_ready low in RUN/ERR, stalls on in_valid gaps. HACK_ROM_LOADER_CHECKSUM_EN adds a mod-256 trailer byte check.
module hack_rom_loader
  import hack_rom_loader_pkg::*;
#(
  parameter int ROM_AW = 15,
  parameter int LEN_W  = LEN_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reload,
  input  logic [14:0] pc,
  output logic [15:0] instruction,
  output logic        cpu_reset,
  output logic        busy,
  output logic        error
);

  localparam logic [32:0] ROM_DEPTH = 33'(1) << ROM_AW;

  loaderState_t       state;
  logic [ROM_AW:0]    wrAddr;
  logic [LEN_W-1:0]   remaining;
  logic [7:0]         lenHi;
  logic [7:0]         dataHi;
  logic               runRead;
  logic [15:0]        romData;
  logic               loading;
  logic               xfer;
  logic               romWe;
  logic [LEN_W-1:0]   lenWord;
  logic               lenTooBig;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  logic [7:0]         chkSum;
`endif

  always_comb begin
    loading = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO: loading = 1'b1;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
      CHK:                              loading = 1'b1;
`endif
      default:                          loading = 1'b0;
    endcase
  end

  assign in_ready  = reset_n & loading;
  assign xfer      = in_valid & in_ready;
  assign lenWord   = LEN_W'({lenHi, in_data});
  assign lenTooBig = 33'(lenWord) > ROM_DEPTH;
  // The extra wrAddr bit only sets once the ROM is full; it blocks any wrap-around write.
  assign romWe     = (state == DATA_LO) && xfer && !wrAddr[ROM_AW];

  hack_rom_bank #(
    .AW (ROM_AW),
    .DW (16)
  ) u_bank (
    .clk    (clk),
    .wrEn   (romWe),
    .wrAddr (wrAddr[ROM_AW-1:0]),
    .wrData ({dataHi, in_data}),
    .rdAddr (pc[ROM_AW-1:0]),
    .rdData (romData)
  );

  // runRead tracks whether the bank read on the last edge happened in RUN.
  assign instruction = runRead ? romData : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= LEN_HI;
      wrAddr    <= '0;
      remaining <= '0;
      lenHi     <= '0;
      dataHi    <= '0;
      runRead   <= 1'b0;
      cpu_reset <= 1'b1;
      busy      <= 1'b1;
      error     <= 1'b0;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
      chkSum    <= '0;
`endif
    end else begin
      runRead <= (state == RUN);
      case (state)
        LEN_HI: begin
          if (xfer) begin
            lenHi <= in_data;
            state <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            if (lenWord == '0) begin
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
              state     <= CHK;
`else
              state     <= RUN;
              cpu_reset <= 1'b0;
              busy      <= 1'b0;
`endif
            end else if (lenTooBig) begin
              state <= ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              remaining <= lenWord;
              state     <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (xfer) begin
            dataHi <= in_data;
            state  <= DATA_LO;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
            chkSum <= chkSum + in_data;
`endif
          end
        end
        DATA_LO: begin
          if (xfer) begin
            wrAddr    <= wrAddr + (ROM_AW+1)'(1);
            remaining <= remaining - LEN_W'(1);
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
            chkSum    <= chkSum + in_data;
`endif
            if (remaining == LEN_W'(1)) begin
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
              state     <= CHK;
`else
              state     <= RUN;
              cpu_reset <= 1'b0;
              busy      <= 1'b0;
`endif
            end else begin
              state <= DATA_HI;
            end
          end
        end
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            busy <= 1'b0;
            if (in_data == chkSum) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        RUN, ERR: begin
          if (reload) begin
            state     <= LEN_HI;
            wrAddr    <= '0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
            chkSum    <= '0;
`endif
          end
        end
        default: state <= LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Randomised bench for hack_rom_loader (ROM_AW=4) against a stream-level model of expected ROM contents and status.
module tb_hack_rom_loader;

  localparam int ROM_AW = 4;
  localparam int DEPTH  = 1 << ROM_AW;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic        reload;
  logic [14:0] pc;
  logic [15:0] instruction;
  logic        cpuReset;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [15:0] romModel [DEPTH];
  bit          romKnown [DEPTH];
  logic [15:0] wordsQ [$];
  int          modelMode = 0;  // 0 loading, 1 running, 2 failed
  int          gapMin = 0;
  int          gapMax = 0;

  hack_rom_loader #(.ROM_AW(ROM_AW), .LEN_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (inData),
    .in_valid    (inValid),
    .in_ready    (inReady),
    .reload      (reload),
    .pc          (pc),
    .instruction (instruction),
    .cpu_reset   (cpuReset),
    .busy        (busy),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Idle gap cycles may carry stray reload pulses, which must be ignored while loading.
  task automatic sendByte(input logic [7:0] b);
    int tmo = 0;
    int gap = $urandom_range(gapMax, gapMin);
    inValid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      reload = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    reload  = 1'b0;
    inData  = b;
    inValid = 1'b1;
    while (!inReady && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    @(negedge clk);
    inValid = 1'b0;
    inData  = $urandom;
    checkVal("sendTimeout", 32'(tmo >= 50), 32'd0);
  endtask

  task automatic pulseReload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkVal("reloadInReady", 32'(inReady), 32'd1);
    checkVal("reloadError", 32'(error), 32'd0);
    checkVal("reloadCpuReset", 32'(cpuReset), 32'd1);
    checkVal("reloadBusy", 32'(busy), 32'd1);
    modelMode = 0;
  endtask

  task automatic checkStatus();
    if (modelMode == 1) begin
      checkVal("runCpuReset", 32'(cpuReset), 32'd0);
      checkVal("runBusy", 32'(busy), 32'd0);
      checkVal("runError", 32'(error), 32'd0);
      checkVal("runInReady", 32'(inReady), 32'd0);
    end else begin
      checkVal("errCpuReset", 32'(cpuReset), 32'd1);
      checkVal("errBusy", 32'(busy), 32'd0);
      checkVal("errError", 32'(error), 32'd1);
      checkVal("errInReady", 32'(inReady), 32'd0);
      checkVal("errInstr", 32'(instruction), 32'h0);
    end
  endtask

  task automatic readBack();
    logic [14:0] pcRand;
    logic [3:0]  a4;
    for (int a = 0; a < DEPTH; a++) begin
      if (romKnown[a]) begin
        pcRand = 15'($urandom);
        a4     = 4'(a);
        pc     = {pcRand[14:4], a4};
        @(negedge clk);
        checkVal("romWord", 32'(instruction), 32'(romModel[a]));
      end
    end
  endtask

  // Streams LEN plus the first n entries of wordsQ, then checks the outcome the stream rules predict.
  task automatic doLoad(input int n, input bit badChk);
    logic [15:0] lenV;
    logic [15:0] w;
    logic [7:0]  sum;
    logic [7:0]  trailer;
    bit          expErr;
    if (modelMode != 0) pulseReload();
    lenV = 16'(n);
    sendByte(lenV[15:8]);
    sendByte(lenV[7:0]);
    expErr = (n > DEPTH);
    sum    = 8'h00;
    if (!expErr) begin
      if (n > 0) checkVal("instrWhileLoading", 32'(instruction), 32'h0);
      for (int i = 0; i < n; i++) begin
        w = wordsQ[i];
        sendByte(w[15:8]);
        sendByte(w[7:0]);
        romModel[i] = w;
        romKnown[i] = 1'b1;
        sum = sum + w[15:8] + w[7:0];
      end
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
      trailer = badChk ? sum + 8'd1 : sum;
      sendByte(trailer);
      expErr = badChk;
`else
      trailer = sum;
`endif
    end
    modelMode = expErr ? 2 : 1;
    checkStatus();
    if (!expErr) readBack();
  endtask

  task automatic fillRandom(input int n);
    wordsQ.delete();
    for (int i = 0; i < n; i++) wordsQ.push_back(16'($urandom));
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    inValid = 1'b0;
    inData  = 8'h00;
    reload  = 1'b0;
    pc      = 15'h0;
    for (int i = 0; i < DEPTH; i++) romKnown[i] = 1'b0;

    @(negedge clk);
    @(negedge clk);
    checkVal("rstInReady", 32'(inReady), 32'd0);
    checkVal("rstCpuReset", 32'(cpuReset), 32'd1);
    checkVal("rstBusy", 32'(busy), 32'd1);
    checkVal("rstError", 32'(error), 32'd0);
    checkVal("rstInstr", 32'(instruction), 32'h0);
    reset_n = 1'b1;
    #1;
    checkVal("postRstInReady", 32'(inReady), 32'd1);
    @(negedge clk);

    // Basic two-word load, back to back.
    wordsQ = '{16'h1234, 16'hABCD};
    doLoad(2, 1'b0);

    // Empty program.
    doLoad(0, 1'b0);

    // Oversize length, then reload recovers.
    doLoad(DEPTH + 1, 1'b0);
    pulseReload();
    modelMode = 0;

    // Exactly full ROM.
    fillRandom(DEPTH);
    doLoad(DEPTH, 1'b0);

    // Overwrite with different values, then the same two words with 2-cycle gaps.
    wordsQ = '{16'h5555, 16'h6666};
    doLoad(2, 1'b0);
    gapMin = 2;
    gapMax = 2;
    wordsQ = '{16'h1234, 16'hABCD};
    doLoad(2, 1'b0);
    gapMin = 0;
    gapMax = 0;

    // Reset after three data bytes: word 0 is committed, word 1 keeps its old value.
    pulseReload();
    sendByte(8'h00);
    sendByte(8'h02);
    sendByte(8'h12);
    sendByte(8'h34);
    sendByte(8'hAB);
    romModel[0] = 16'h1234;
    reset_n = 1'b0;
    #1;
    checkVal("midRstInReady", 32'(inReady), 32'd0);
    @(negedge clk);
    checkVal("midRstCpuReset", 32'(cpuReset), 32'd1);
    checkVal("midRstBusy", 32'(busy), 32'd1);
    reset_n = 1'b1;
    #1;
    checkVal("midRstLenHi", 32'(inReady), 32'd1);
    @(negedge clk);
    modelMode = 0;
    wordsQ = '{16'hBEEF};
    doLoad(1, 1'b0);

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    fillRandom(3);
    doLoad(3, 1'b1);
    fillRandom(3);
    doLoad(3, 1'b0);
`endif

    // Random loads with random gaps and occasional oversize lengths.
    gapMax = 2;
    for (int t = 0; t < 25; t++) begin
      n = ($urandom_range(0, 6) == 0) ? int'($urandom_range(DEPTH + 1, 600)) : int'($urandom_range(0, DEPTH));
      fillRandom(n > DEPTH ? 0 : n);
      doLoad(n, ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
